// File: rtl/uart_frame_sequencer_pkg.sv
// Shared types and constants for the UART frame sequencer.
// Holds the FSM state encoding and the widths used across the block.
package uart_seq_pkg;

    localparam int DEFAULT_ADDR_W = 16;
    localparam int BYTE_W         = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        READ   = 3'd1,
        LOAD   = 3'd2,
        SEND   = 3'd3,
        GAP    = 3'd4,
        FINISH = 3'd5
    } state_t;

endpackage

// File: rtl/uart_frame_sequencer_gap_timer.sv
// Down-counter that times the idle gap between bytes.
// expired is high on the last cycle of the gap.
module gap_timer #(
    parameter int CYCLES = 1,
    parameter int WIDTH  = $clog2(CYCLES + 1)
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    output logic expired
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (!rst) begin
            count <= '0;
        end else if (load) begin
            count <= WIDTH'(CYCLES);
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    // Loading CYCLES makes the GAP state last exactly CYCLES clocks.
    assign expired = (count == WIDTH'(1));

endmodule

// File: rtl/uart_frame_sequencer.sv
// Streams a stored byte frame from a synchronous memory into uart_tx,
// with an optional idle gap after every accepted byte.
module uart_frame_sequencer
    import uart_seq_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int GAP_CYCLES = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W-1:0] len,
    output logic              mem_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [BYTE_W-1:0] mem_rdata,
    output logic [BYTE_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] byte_count
);

    state_t            state;
    logic [ADDR_W-1:0] len_q;
    logic              last_byte;
    logic              gap_expired;

    assign last_byte = ((byte_count + 1'b1) == len_q);

    generate
        if (GAP_CYCLES > 0) begin : g_gap
            logic gap_load;

            // An aborted handshake must not start a gap.
            assign gap_load = (state == SEND) && tx_valid && tx_ready && !last_byte && !abort;

            gap_timer #(
                .CYCLES(GAP_CYCLES)
            ) u_gap_timer (
                .clk,
                .rst,
                .load   (gap_load),
                .expired(gap_expired)
            );
        end else begin : g_no_gap
            assign gap_expired = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            len_q      <= '0;
            mem_en     <= 1'b0;
            mem_addr   <= '0;
            tx_data    <= '0;
            tx_valid   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            byte_count <= '0;
        end else begin
            mem_en <= 1'b0;
            done   <= 1'b0;
            // Abort beats everything, including a handshake in the same cycle.
            if (abort) begin
                state    <= IDLE;
                tx_valid <= 1'b0;
                busy     <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            byte_count <= '0;
                            if (len != '0) begin
                                len_q    <= len;
                                mem_addr <= '0;
                                busy     <= 1'b1;
                                mem_en   <= 1'b1;
                                state    <= READ;
                            end else begin
                                state <= FINISH;
                            end
                        end
                    end
                    READ: state <= LOAD;
                    LOAD: begin
                        tx_data  <= mem_rdata;
                        tx_valid <= 1'b1;
                        state    <= SEND;
                    end
                    SEND: begin
                        if (tx_valid && tx_ready) begin
                            tx_valid   <= 1'b0;
                            byte_count <= byte_count + 1'b1;
                            if (last_byte) begin
                                state <= FINISH;
                            end else begin
                                mem_addr <= mem_addr + 1'b1;
                                if (GAP_CYCLES > 0) begin
                                    state <= GAP;
                                end else begin
                                    mem_en <= 1'b1;
                                    state  <= READ;
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (gap_expired) begin
                            mem_en <= 1'b1;
                            state  <= READ;
                        end
                    end
                    FINISH: begin
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Self-checking bench for uart_frame_sequencer: a gapless and a GAP=5 instance
// share stimulus and are compared every cycle against a frame-schedule model.
module tb_uart_frame_sequencer;

    localparam int GAP_B = 5;

    logic        clk = 1'b0;
    logic        rst, start, abort, tx_ready;
    logic [15:0] len;

    logic        mem_en0, tx_valid0, busy0, done0;
    logic [15:0] mem_addr0, count0;
    logic [7:0]  rdata0, tx_data0;
    logic        mem_en5, tx_valid5, busy5, done5;
    logic [15:0] mem_addr5, count5;
    logic [7:0]  rdata5, tx_data5;

    logic [7:0]  mem_img [256];

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    bit checking = 1'b0;
    int s_cyc;

    typedef struct {
        bit         run;
        bit         fin;
        bit         fbusy;
        int         fin_c;
        int         done_c;
        int         k;
        int         len_q;
        int         fetch_c;
        int         count;
        logic [7:0] data;
    } model_t;

    typedef struct packed {
        logic        mem_en;
        logic [15:0] addr;
        logic        tx_valid;
        logic [7:0]  tx_data;
        logic        busy;
        logic        done;
        logic [15:0] count;
    } obs_t;

    model_t m0, m5;

    int         hs_cyc0[$];
    logic [7:0] hs_data0[$];
    int         mem_en_cyc0[$];
    logic [15:0] mem_en_addr0[$];
    int         done_cyc0[$];
    int         valid_cnt0, busy_cnt0;
    int         hs_cyc5[$];
    int         mem_en_cyc5[$];
    int         done_cyc5[$];

    logic [7:0] exp_bytes [4];

    uart_frame_sequencer #(.ADDR_W(16), .GAP_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .mem_en(mem_en0), .mem_addr(mem_addr0), .mem_rdata(rdata0),
        .tx_data(tx_data0), .tx_valid(tx_valid0), .tx_ready(tx_ready),
        .busy(busy0), .done(done0), .byte_count(count0)
    );

    uart_frame_sequencer #(.ADDR_W(16), .GAP_CYCLES(GAP_B)) dut5 (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .len(len),
        .mem_en(mem_en5), .mem_addr(mem_addr5), .mem_rdata(rdata5),
        .tx_data(tx_data5), .tx_valid(tx_valid5), .tx_ready(tx_ready),
        .busy(busy5), .done(done5), .byte_count(count5)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_en0) rdata0 <= mem_img[mem_addr0[7:0]];
        if (mem_en5) rdata5 <= mem_img[mem_addr5[7:0]];
    end

    // Frame schedule: byte k is fetched at fetch_c, offered from fetch_c+2 until
    // accepted; the next fetch is gap+1 cycles after the accepting cycle.
    function automatic model_t advance(input model_t m, input logic rst_v, input logic start_v,
                                       input logic abort_v, input logic [15:0] len_v,
                                       input logic ready_v, input int gap, input int c);
        model_t n = m;
        if (!rst_v) begin
            n.run = 0; n.fin = 0; n.fbusy = 0; n.fin_c = -1; n.done_c = -1;
            n.k = 0; n.len_q = 0; n.fetch_c = 0; n.count = 0; n.data = 8'h00;
        end else if (abort_v) begin
            if (m.run && c >= m.fetch_c + 2) n.data = mem_img[m.k[7:0]];
            n.run = 0; n.fin = 0; n.done_c = -1;
        end else if (!m.run && !m.fin) begin
            if (start_v) begin
                n.count = 0;
                if (len_v != 16'd0) begin
                    n.run = 1; n.len_q = int'(len_v); n.k = 0; n.fetch_c = c + 1;
                end else begin
                    n.fin = 1; n.fbusy = 0; n.fin_c = c + 1; n.done_c = c + 2;
                end
            end
        end else if (m.run) begin
            if (c >= m.fetch_c + 2 && ready_v) begin
                n.count = m.count + 1;
                n.data  = mem_img[m.k[7:0]];
                if (n.count == m.len_q) begin
                    n.run = 0; n.fin = 1; n.fbusy = 1; n.fin_c = c + 1; n.done_c = c + 2;
                end else begin
                    n.k = m.k + 1; n.fetch_c = c + 1 + gap;
                end
            end
        end else if (c >= m.fin_c) begin
            n.fin = 0;
        end
        return n;
    endfunction

    function automatic obs_t predict(input model_t m, input int c);
        obs_t e;
        e.mem_en   = m.run && (c == m.fetch_c);
        e.addr     = m.k[15:0];
        e.tx_valid = m.run && (c >= m.fetch_c + 2);
        e.tx_data  = e.tx_valid ? mem_img[m.k[7:0]] : m.data;
        e.busy     = m.run || (m.fin && m.fbusy);
        e.done     = (c == m.done_c);
        e.count    = m.count[15:0];
        return e;
    endfunction

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    task automatic check_cycle(input string name, input obs_t act, input obs_t exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s cycle %0d: got en=%b addr=%h vld=%b data=%h busy=%b done=%b cnt=%0d, expected en=%b addr=%h vld=%b data=%h busy=%b done=%b cnt=%0d",
                     name, cyc, act.mem_en, act.addr, act.tx_valid, act.tx_data, act.busy, act.done, act.count,
                     exp.mem_en, exp.addr, exp.tx_valid, exp.tx_data, exp.busy, exp.done, exp.count);
        end
    endtask

    always @(posedge clk) begin
        m0 = advance(m0, rst, start, abort, len, tx_ready, 0, cyc);
        m5 = advance(m5, rst, start, abort, len, tx_ready, GAP_B, cyc);
        if (!rst) checking = 1'b1;
        cyc = cyc + 1;
    end

    always @(negedge clk) begin
        if (checking) begin
            check_cycle("dut0", {mem_en0, mem_addr0, tx_valid0, tx_data0, busy0, done0, count0}, predict(m0, cyc));
            check_cycle("dut5", {mem_en5, mem_addr5, tx_valid5, tx_data5, busy5, done5, count5}, predict(m5, cyc));
            if (mem_en0) begin mem_en_cyc0.push_back(cyc); mem_en_addr0.push_back(mem_addr0); end
            if (tx_valid0 && tx_ready) begin hs_cyc0.push_back(cyc); hs_data0.push_back(tx_data0); end
            if (done0) done_cyc0.push_back(cyc);
            if (tx_valid0) valid_cnt0++;
            if (busy0) busy_cnt0++;
            if (mem_en5) mem_en_cyc5.push_back(cyc);
            if (tx_valid5 && tx_ready) hs_cyc5.push_back(cyc);
            if (done5) done_cyc5.push_back(cyc);
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic apply_stimulus(input logic s, input logic [15:0] l, input logic a, input logic r);
        start    = s;
        len      = l;
        abort    = a;
        tx_ready = r;
    endtask

    task automatic clear_monitor();
        hs_cyc0.delete(); hs_data0.delete(); mem_en_cyc0.delete(); mem_en_addr0.delete();
        done_cyc0.delete(); valid_cnt0 = 0; busy_cnt0 = 0;
        hs_cyc5.delete(); mem_en_cyc5.delete(); done_cyc5.delete();
    endtask

    task automatic pulse_start(input logic [15:0] l, input logic r);
        s_cyc = cyc;
        apply_stimulus(1'b1, l, 1'b0, r);
        step(1);
        apply_stimulus(1'b0, l, 1'b0, r);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mem_img[i] = 8'(i * 7 + 3);
        mem_img[0] = 8'h50; mem_img[1] = 8'h36; mem_img[2] = 8'h0A; mem_img[3] = 8'hFF;
        exp_bytes[0] = 8'h50; exp_bytes[1] = 8'h36; exp_bytes[2] = 8'h0A; exp_bytes[3] = 8'hFF;

        rst = 1'b0;
        apply_stimulus(1'b1, 16'd4, 1'b0, 1'b1);
        step(3);
        check_output("reset mem_en", {31'd0, mem_en0}, 32'd0);
        check_output("reset tx_valid", {31'd0, tx_valid0}, 32'd0);
        check_output("reset busy", {31'd0, busy0}, 32'd0);
        check_output("reset byte_count", {16'd0, count0}, 32'd0);
        check_output("reset mem_addr", {16'd0, mem_addr0}, 32'd0);
        check_output("reset gap mem_en", {31'd0, mem_en5}, 32'd0);
        apply_stimulus(1'b0, 16'd4, 1'b0, 1'b1);
        rst = 1'b1;
        step(2);

        // Four-byte frame, no backpressure.
        clear_monitor();
        pulse_start(16'd4, 1'b1);
        step(40);
        check_output("frame4 bytes", hs_data0.size(), 32'd4);
        if (hs_data0.size() == 4) begin
            for (int i = 0; i < 4; i++) check_output("frame4 data", {24'd0, hs_data0[i]}, {24'd0, exp_bytes[i]});
            for (int i = 1; i < 4; i++) check_output("frame4 spacing", hs_cyc0[i] - hs_cyc0[i-1], 32'd3);
            check_output("frame4 first latency", hs_cyc0[0] - s_cyc, 32'd3);
        end
        check_output("frame4 done pulses", done_cyc0.size(), 32'd1);
        check_output("frame4 byte_count", {16'd0, count0}, 32'd4);
        check_output("frame4 busy after", {31'd0, busy0}, 32'd0);

        // Backpressure on the first byte for ten offered cycles.
        clear_monitor();
        pulse_start(16'd2, 1'b0);
        step(12);
        apply_stimulus(1'b0, 16'd2, 1'b0, 1'b1);
        step(40);
        check_output("bp valid cycles", valid_cnt0, 32'd12);
        check_output("bp reads", mem_en_cyc0.size(), 32'd2);
        check_output("bp first accept", hs_cyc0.size() > 0 ? hs_cyc0[0] - s_cyc : -1, 32'd13);
        check_output("bp first byte", hs_data0.size() > 0 ? {24'd0, hs_data0[0]} : 32'hFFFF, 32'h50);
        check_output("bp byte_count", {16'd0, count0}, 32'd2);

        // Gap instance, three bytes.
        clear_monitor();
        pulse_start(16'd3, 1'b1);
        step(40);
        check_output("gap accepts", hs_cyc5.size(), 32'd3);
        if (hs_cyc5.size() == 3 && mem_en_cyc5.size() == 3) begin
            check_output("gap first read", mem_en_cyc5[0] - s_cyc, 32'd1);
            for (int i = 0; i < 2; i++) check_output("gap accept to read", mem_en_cyc5[i+1] - hs_cyc5[i], 32'd6);
        end
        check_output("gap done pulses", done_cyc5.size(), 32'd1);
        check_output("gap done time", done_cyc5.size() > 0 ? done_cyc5[0] - s_cyc : -1, 32'd21);
        check_output("gap byte_count", {16'd0, count5}, 32'd3);

        // Empty frame.
        clear_monitor();
        pulse_start(16'd0, 1'b1);
        step(10);
        check_output("empty done pulses", done_cyc0.size(), 32'd1);
        check_output("empty done time", done_cyc0.size() > 0 ? done_cyc0[0] - s_cyc : -1, 32'd2);
        check_output("empty tx_valid", valid_cnt0, 32'd0);
        check_output("empty busy", busy_cnt0, 32'd0);
        check_output("empty byte_count", {16'd0, count0}, 32'd0);

        // Second start while busy must be ignored.
        clear_monitor();
        pulse_start(16'd3, 1'b1);
        step(3);
        apply_stimulus(1'b1, 16'd7, 1'b0, 1'b1);
        step(1);
        apply_stimulus(1'b0, 16'd7, 1'b0, 1'b1);
        step(40);
        check_output("restart ignored bytes", hs_cyc0.size(), 32'd3);
        check_output("restart ignored count", {16'd0, count0}, 32'd3);
        check_output("restart ignored done", done_cyc0.size(), 32'd1);

        // Abort on the third byte's handshake cycle.
        clear_monitor();
        pulse_start(16'd8, 1'b1);
        step(8);
        apply_stimulus(1'b0, 16'd8, 1'b1, 1'b1);
        step(1);
        apply_stimulus(1'b0, 16'd8, 1'b0, 1'b1);
        check_output("abort tx_valid", {31'd0, tx_valid0}, 32'd0);
        check_output("abort busy", {31'd0, busy0}, 32'd0);
        step(5);
        check_output("abort byte_count", {16'd0, count0}, 32'd2);
        check_output("abort gap byte_count", {16'd0, count5}, 32'd1);
        check_output("abort no done", done_cyc0.size(), 32'd0);

        clear_monitor();
        pulse_start(16'd2, 1'b1);
        step(40);
        check_output("after abort first addr", mem_en_addr0.size() > 0 ? {16'd0, mem_en_addr0[0]} : 32'hFFFF, 32'd0);
        check_output("after abort first read", mem_en_cyc0.size() > 0 ? mem_en_cyc0[0] - s_cyc : -1, 32'd1);
        check_output("after abort byte_count", {16'd0, count0}, 32'd2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
